// File: rtl/design_file_four_ip_nand.sv
// Four-input NAND built from 2-input NAND cells, plus a registered copy, a sticky-valid flag and a saturating low counter.
// Optional structural self-check: define DESIGN_FILE_FOUR_IP_NAND_SELF_CHECK_EN to build it; otherwise err is tied low.

module design_file_four_ip_nand_nand2 (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(i_a & i_b);
endmodule

module design_file_four_ip_nand (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i,
    output logic       y,
    output logic       y_q,
    output logic       y_valid,
    output logic [7:0] low_cnt,
    output logic       err
);
    logic w_n0;
    logic w_n1;
    logic w_a0;
    logic w_a1;
    logic w_y;

    logic       r_y_q;
    logic       r_y_valid;
    logic [7:0] r_low_cnt;

    // Pairwise NANDs, each turned back into an AND by a self-NAND, then combined.
    design_file_four_ip_nand_nand2 u_n0 (.i_a(i[0]), .i_b(i[1]), .o_y(w_n0));
    design_file_four_ip_nand_nand2 u_n1 (.i_a(i[2]), .i_b(i[3]), .o_y(w_n1));
    design_file_four_ip_nand_nand2 u_a0 (.i_a(w_n0), .i_b(w_n0), .o_y(w_a0));
    design_file_four_ip_nand_nand2 u_a1 (.i_a(w_n1), .i_b(w_n1), .o_y(w_a1));
    design_file_four_ip_nand_nand2 u_y  (.i_a(w_a0), .i_b(w_a1), .o_y(w_y));

    assign y = w_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q     <= 1'b1;
            r_y_valid <= 1'b0;
            r_low_cnt <= 8'h00;
        end else begin
            r_y_q     <= w_y;
            r_y_valid <= 1'b1;
            if (!w_y && (r_low_cnt != 8'hFF)) begin
                r_low_cnt <= r_low_cnt + 8'h01;
            end
        end
    end

    assign y_q     = r_y_q;
    assign y_valid = r_y_valid;
    assign low_cnt = r_low_cnt;

`ifdef DESIGN_FILE_FOUR_IP_NAND_SELF_CHECK_EN
    logic w_y_ref;
    logic r_err;

    // Behavioral reference kept independent of the gate network above.
    assign w_y_ref = ~&i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_y != w_y_ref) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_design_file_four_ip_nand.sv
// Directed bench for design_file_four_ip_nand: reset state, truth-table sweep, latency, saturation and mid-run reset.

module tb_design_file_four_ip_nand;

    logic       clk;
    logic       rst;
    logic [3:0] i;
    logic       y;
    logic       y_q;
    logic       y_valid;
    logic [7:0] low_cnt;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;

    logic exp_q[$];

    design_file_four_ip_nand dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .y       (y),
        .y_q     (y_q),
        .y_valid (y_valid),
        .low_cnt (low_cnt),
        .err     (err)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 ns after a rising edge, outputs are sampled there too.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        logic [15:0] y_table;
        logic        exp_y;

        rst = 1'b1;
        i   = 4'b0000;
        tick(2);
        check("rst_y_q",     {7'd0, y_q},     8'h01);
        check("rst_y_valid", {7'd0, y_valid}, 8'h00);
        check("rst_low_cnt", low_cnt,         8'h00);
        check("rst_err",     {7'd0, err},     8'h00);
        check("rst_y_comb",  {7'd0, y},       8'h01);

        // Latency: first non-reset edge samples i=1111.
        rst = 1'b0;
        i   = 4'b1111;
        #1;
        check("lat_y_comb", {7'd0, y}, 8'h00);
        tick(1);
        check("lat_y_q_low",   {7'd0, y_q},     8'h00);
        check("lat_y_valid",   {7'd0, y_valid}, 8'h01);
        check("lat_low_cnt_1", low_cnt,         8'h01);
        i = 4'b0000;
        #1;
        check("lat_y_q_hold", {7'd0, y_q}, 8'h00);
        tick(1);
        check("lat_y_q_high",   {7'd0, y_q}, 8'h01);
        check("lat_low_cnt_hold", low_cnt,   8'h01);

        // Sweep: hand-written truth table, bit v is y for i=v.
        y_table = 16'h7FFF;
        for (int v = 0; v < 16; v++) exp_q.push_back(y_table[v]);
        for (int v = 0; v < 16; v++) begin
            i = v[3:0];
            #1;
            exp_y = exp_q.pop_front();
            check($sformatf("sweep_y_%0d", v), {7'd0, y}, {7'd0, exp_y});
            tick(1);
        end
        check("sweep_err", {7'd0, err}, 8'h00);

        // Counter: fresh reset, then hold i=1111 for 32 edges.
        rst = 1'b1;
        i   = 4'b0000;
        tick(1);
        rst = 1'b0;
        i   = 4'b1111;
        tick(32);
        check("cnt_0x20", low_cnt, 8'h20);

        // Mid-run reset with the increment condition active: reset wins.
        rst = 1'b1;
        #1;
        check("midrst_y_low", {7'd0, y}, 8'h00);
        i = 4'b0000;
        #1;
        check("midrst_y_tracks", {7'd0, y}, 8'h01);
        i = 4'b1111;
        tick(1);
        check("midrst_low_cnt", low_cnt,         8'h00);
        check("midrst_y_q",     {7'd0, y_q},     8'h01);
        check("midrst_y_valid", {7'd0, y_valid}, 8'h00);
        check("midrst_err",     {7'd0, err},     8'h00);

        // Saturation: 300 edges at i=1111.
        rst = 1'b0;
        tick(254);
        check("sat_0xfe", low_cnt, 8'hFE);
        tick(1);
        check("sat_0xff", low_cnt, 8'hFF);
        tick(45);
        check("sat_stay", low_cnt, 8'hFF);
        check("sat_y_q",  {7'd0, y_q}, 8'h00);
        i = 4'b0000;
        tick(5);
        check("sat_hold_y1", low_cnt,     8'hFF);
        check("sat_y_q_1",   {7'd0, y_q}, 8'h01);
        check("final_err",   {7'd0, err}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/design_file_four_ip_nand.md
DESIGN_FILE_FOUR_IP_NAND -- requirements
Module: design_file_four_ip_nand

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, synchronous, active-high.
REQ-003: i  input  4  NAND operand bits i[3:0].
REQ-004: y  output  1  combinational 4-input NAND of i.
REQ-005: y_q  output  1  y registered on clk.
REQ-006: y_valid  output  1  high once y_q holds a sampled value since reset.
REQ-007: low_cnt  output  8  saturating count of clk edges on which y was sampled low.
REQ-008: err  output  1  sticky self-check mismatch flag.

Function
REQ-009: y SHALL equal NOT(i[3] AND i[2] AND i[1] AND i[0]) at all times, independent of clk and rst.
- y is low only for i=4'b1111.
REQ-010: y SHALL be built solely from instances of a 2-input NAND submodule, five instances in total:
- n0 = NAND(i[0], i[1]).
- n1 = NAND(i[2], i[3]).
- a0 = NAND(n0, n0).
- a1 = NAND(n1, n1).
- y = NAND(a0, a1).
REQ-011: The y path SHALL be purely combinational, with no latch and no clocked element.
- y settles within one simulation delta of a change on i.
REQ-012: y_q SHALL take the value of y on each rising clk edge when rst=0, giving 1-cycle latency.
REQ-013: y_valid SHALL go high on the first rising edge with rst=0 and stay high until the next reset.
REQ-014: low_cnt SHALL increment by 1 on each rising edge with rst=0 and y=0.
- It saturates at 8'hFF and does not wrap.
- It holds when y=1.
REQ-015: If rst and the increment condition are both true on the same edge, rst SHALL win.
REQ-016: If no i bit is X or Z, no output SHALL be X after the first reset.

Reset
REQ-017: On a rising clk edge with rst=1, the following SHALL load:
- y_q = 1'b1.
- y_valid = 0.
- low_cnt = 8'h00.
- err = 0.
REQ-018: y SHALL be unaffected by rst.
REQ-019: Asserting rst mid-operation SHALL discard the count and flag immediately on that edge.
- Normal operation resumes on the first edge with rst=0.

Configuration
REQ-020: When macro DESIGN_FILE_FOUR_IP_NAND_SELF_CHECK_EN is defined, the self-check SHALL be compiled in:
- Each rising edge with rst=0 compares y against an independent behavioral ~&i.
- On mismatch, err is set and stays high until reset.
REQ-021: When DESIGN_FILE_FOUR_IP_NAND_SELF_CHECK_EN is undefined:
- No comparison logic is built.
- err is tied to 0.
- The port list is unchanged.

Verification
REQ-022: Exhaustive sweep: apply i=0..15, holding each value 10 ns.
- y=1 for i=0000..1110.
- y=0 for i=1111.
- No X on y at any step.
REQ-023: Latency check: rst for 2 cycles, then i=1111 before edge k.
- y_q=0 after edge k.
- y_valid=1 from the first non-reset edge.
- y_q=1 one edge after i returns to 0000.
REQ-024: Counter check: hold i=1111 for 300 cycles.
- low_cnt reaches 8'hFF and stays at 8'hFF.
- Then i=0000: low_cnt holds 8'hFF.
REQ-025: Reset mid-run: low_cnt=8'h20, then assert rst for 1 edge.
- low_cnt=0, y_q=1, y_valid=0, err=0.
- y still tracks i combinationally during reset.
REQ-026: Self-check: with the macro defined, run the full sweep.
- err stays 0.
- With the macro undefined, err is constantly 0.
